// File: rtl/multi_mode_adder_pkg.sv
// Shared types and saturation helpers for the multi-mode adder.
package multi_mode_adder_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  function automatic logic [63:0] sat_max(input int w);
    sat_max = (64'(1) << (w - 1)) - 64'(1);
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    sat_min = 64'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/add_sub_core.sv
// Combinational WIDTH+1 add/subtract with carry, overflow and optional clamp.
module add_sub_core
  import multi_mode_adder_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 0
) (
  input  mode_e            mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             sub;
  logic [WIDTH:0]   sum;

  always_comb begin
    x   = op_a;
    y   = op_b;
    sub = 1'b0;
    unique case (mode)
      MODE_ADD:  ;
      MODE_SUB:  sub = 1'b1;
      MODE_ACC: begin
        x = acc;
        y = op_a;
      end
      MODE_LOAD: y = '0;
    endcase
  end

  always_comb begin
    if (sub) sum = {1'b0, x} - {1'b0, y};
    else     sum = {1'b0, x} + {1'b0, y};
  end

  // LOAD adds zero, so carry and overflow fall out as 0.
  always_comb begin
    carry = sum[WIDTH];
    if (sub) overflow = (x[WIDTH-1] != y[WIDTH-1]);
    else     overflow = (x[WIDTH-1] == y[WIDTH-1]);
    overflow = overflow && (sum[WIDTH-1] != x[WIDTH-1]);
    result = sum[WIDTH-1:0];
    if (SATURATE != 0 && overflow)
      result = x[WIDTH-1] ? SMIN : SMAX;
  end

endmodule

// File: rtl/multi_mode_adder.sv
// Pipelined ADD/SUB/ACC/LOAD unit with accumulator and valid/ready flow.
module multi_mode_adder
  import multi_mode_adder_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int STAGES   = 2,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
  } res_t;

  mode_e             m;
  logic [WIDTH-1:0]  acc;
  res_t              core;
  res_t              data [STAGES];
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] en;
  logic              in_fire;

  assign m = mode_e'(mode);

  add_sub_core #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_core (
    .mode     (m),
    .op_a     (op_a),
    .op_b     (op_b),
    .acc      (acc),
    .result   (core.result),
    .carry    (core.carry),
    .overflow (core.overflow)
  );

  // A stage may advance if the consumer drains or any later stage is empty.
  always_comb begin
    en = '0;
    for (int i = 0; i < STAGES; i++) begin
      en[i] = out_ready;
      for (int j = i; j < STAGES; j++)
        if (!vld[j]) en[i] = 1'b1;
    end
  end

  assign in_ready = en[0];
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      vld <= '0;
      for (int i = 0; i < STAGES; i++)
        data[i] <= '0;
    end else begin
      if (in_fire && (m == MODE_ACC || m == MODE_LOAD))
        acc <= core.result;
      if (en[0]) begin
        vld[0]  <= in_fire;
        data[0] <= in_fire ? core : '0;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (en[i]) begin
          vld[i]  <= vld[i-1];
          data[i] <= data[i-1];
        end
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign result    = data[STAGES-1].result;
  assign carry     = data[STAGES-1].carry;
  assign overflow  = data[STAGES-1].overflow;

endmodule

// File: tb/tb_multi_mode_adder.sv
// Directed bench: wrapping and saturating instances share one stimulus.
module tb_multi_mode_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [1:0]  mode = 2'b00;
  logic        out_ready = 1'b1;

  logic        in_ready0, out_valid0, carry0, overflow0;
  logic [15:0] result0;
  logic        in_ready1, out_valid1, carry1, overflow1;
  logic [15:0] result1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_mode_adder #(.WIDTH(16), .STAGES(2), .SATURATE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .op_a(op_a), .op_b(op_b), .mode(mode), .out_valid(out_valid0),
    .out_ready(out_ready), .result(result0), .carry(carry0),
    .overflow(overflow0)
  );

  multi_mode_adder #(.WIDTH(16), .STAGES(2), .SATURATE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .op_a(op_a), .op_b(op_b), .mode(mode), .out_valid(out_valid1),
    .out_ready(out_ready), .result(result1), .carry(carry1),
    .overflow(overflow1)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated transfer; result checked two edges after acceptance.
  task automatic op_check(input string tag, input logic [1:0] m,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] r0, input logic c,
                          input logic ov, input logic [15:0] r1);
    mode = m; op_a = a; op_b = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, ".early"}, 64'(out_valid0), 64'd0);
    step();
    chk({tag, ".valid"}, 64'(out_valid0), 64'd1);
    chk({tag, ".res"}, 64'(result0), 64'(r0));
    chk({tag, ".carry"}, 64'(carry0), 64'(c));
    chk({tag, ".ovf"}, 64'(overflow0), 64'(ov));
    chk({tag, ".sat_res"}, 64'(result1), 64'(r1));
    chk({tag, ".sat_ovf"}, 64'(overflow1), 64'(ov));
    step();
  endtask

  initial begin : main
    logic [15:0] exp_q [6];
    int nsent, nrecv, cyc;
    logic saw_block, have_hold;
    logic [15:0] hold_val;

    // Reset state
    #12;
    chk("rst.out_valid", 64'(out_valid0), 64'd0);
    chk("rst.result", 64'(result0), 64'd0);
    chk("rst.carry", 64'(carry0), 64'd0);
    chk("rst.ovf", 64'(overflow0), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst.in_ready", 64'(in_ready0), 64'd1);
    step();

    // Basic arithmetic and boundaries
    op_check("add3_4", 2'b00, 16'h0003, 16'h0004, 16'h0007, 0, 0, 16'h0007);
    op_check("add_carry", 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 16'h0000);
    op_check("sub_borrow", 2'b01, 16'h0000, 16'h0001, 16'hFFFF, 1, 0, 16'hFFFF);
    op_check("add_posovf", 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 16'h7FFF);
    op_check("add_negovf", 2'b00, 16'h8000, 16'hFFFF, 16'h7FFF, 1, 1, 16'h8000);
    op_check("sub_negovf", 2'b01, 16'h8000, 16'h0001, 16'h7FFF, 0, 1, 16'h8000);

    // Back-to-back LOAD, ACC, ACC
    mode = 2'b11; op_a = 16'h0010; op_b = 16'hAAAA; in_valid = 1'b1;
    step();
    mode = 2'b10; op_a = 16'h0005;
    step();
    chk("b2b.v0", 64'(out_valid0), 64'd1);
    chk("b2b.load", 64'(result0), 64'h0010);
    chk("b2b.load_c", 64'(carry0), 64'd0);
    step();
    in_valid = 1'b0;
    chk("b2b.v1", 64'(out_valid0), 64'd1);
    chk("b2b.acc1", 64'(result0), 64'h0015);
    step();
    chk("b2b.v2", 64'(out_valid0), 64'd1);
    chk("b2b.acc2", 64'(result0), 64'h001A);
    chk("b2b.sat_acc2", 64'(result1), 64'h001A);
    step();
    chk("b2b.drain", 64'(out_valid0), 64'd0);

    // Stream of six ADDs with a three-cycle consumer stall
    for (int k = 0; k < 6; k++)
      exp_q[k] = 16'(16'h0101 * (k + 1));
    nsent = 0; nrecv = 0; cyc = 0;
    saw_block = 1'b0; have_hold = 1'b0; hold_val = '0;
    mode = 2'b00;
    while (nrecv < 6 && cyc < 40) begin
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid = (nsent < 6);
      op_a = 16'(16'h0100 * (nsent + 1));
      op_b = 16'(nsent + 1);
      #1;
      if (out_valid0 && out_ready) begin
        chk("stream.order", 64'(result0), 64'(exp_q[nrecv]));
        nrecv++;
      end
      if (out_valid0 && !out_ready) begin
        if (have_hold) chk("stream.hold", 64'(result0), 64'(hold_val));
        hold_val = result0;
        have_hold = 1'b1;
      end
      if (!in_ready0) saw_block = 1'b1;
      if (in_valid && in_ready0) nsent++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cyc++;
    end
    out_ready = 1'b1;
    chk("stream.count", 64'(nrecv), 64'd6);
    chk("stream.blocked", 64'(saw_block), 64'd1);
    step();

    // Reset with two transfers in flight
    mode = 2'b10; op_a = 16'h0001; in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst2.out_valid", 64'(out_valid0), 64'd0);
    chk("rst2.result", 64'(result0), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst2.in_ready", 64'(in_ready0), 64'd1);
    step();
    op_check("rst2.acc", 2'b10, 16'h0001, 16'h1234, 16'h0001, 0, 0, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
